// File: rtl/riscv_package.sv
// Shared types and defaults for the writeback path.
// The pending-register scoreboard is optional: it is built only when the
// macro WRITEBACK_SCOREBOARD_EN is defined.
package riscv_package;

  typedef logic [4:0]  register_address_t;
  typedef logic [31:0] word_t;

  // Default number of back-to-back load wins the ALU will tolerate.
  localparam int unsigned WRITEBACK_STARVE_LIMIT = 4;

  // Width of the starvation counter; holds limits in the range 1..15.
  localparam int unsigned STARVE_COUNT_W = 4;

  localparam register_address_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_LOAD = 2'd2
  } grant_t;

  function automatic logic is_zero_reg(input register_address_t addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/writeback_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register x1..x31.
// Used only when WRITEBACK_SCOREBOARD_EN is defined.
module writeback_scoreboard
  import riscv_package::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  register_address_t issue_destination,
  input  logic              clear_valid,
  input  register_address_t clear_destination,
  input  register_address_t source1,
  input  register_address_t source2,
  output logic              busy1,
  output logic              busy2
);

  logic [31:0] pending_q;
  logic [31:0] pending_d;

  // Clear on commit first, then apply the issue so a same-cycle set wins.
  always_comb begin
    pending_d = pending_q;
    if (clear_valid) begin
      pending_d[clear_destination] = 1'b0;
    end
    if (issue_valid && !is_zero_reg(issue_destination)) begin
      pending_d[issue_destination] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Reservation state; a reset drops every outstanding reservation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Hazard queries; bit 0 is never set, so x0 always reads not-busy.
  always_comb begin
    busy1 = pending_q[source1];
    busy2 = pending_q[source2];
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Two-source writeback arbiter (ALU and load) feeding one register-file
// write port, with a starvation guard for the ALU and a registered output.
// Define WRITEBACK_SCOREBOARD_EN to build the pending-register scoreboard
// and live busy1/busy2 outputs; otherwise busy is tied low and issue_* is
// ignored.
module writeback_arbiter
  import riscv_package::*;
#(
  parameter int unsigned STARVE_LIMIT = WRITEBACK_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              alu_valid,
  output logic              alu_ready,
  input  register_address_t alu_destination,
  input  word_t             alu_data,

  input  logic              load_valid,
  output logic              load_ready,
  input  register_address_t load_destination,
  input  word_t             load_data,

  input  logic              issue_valid,
  input  register_address_t issue_destination,

  input  register_address_t source1,
  input  register_address_t source2,
  output logic              busy1,
  output logic              busy2,

  output logic              rf_write_enable,
  output register_address_t rf_destination,
  output word_t             rf_write_data
);

  localparam logic [STARVE_COUNT_W-1:0] LIMIT = STARVE_COUNT_W'(STARVE_LIMIT);

  grant_t                    grant;
  logic                      starve_at_limit;
  logic [STARVE_COUNT_W-1:0] starve_count_q;
  logic [STARVE_COUNT_W-1:0] starve_count_d;

  logic                      rf_write_enable_q;
  logic                      rf_write_enable_d;
  register_address_t         rf_destination_q;
  register_address_t         rf_destination_d;
  word_t                     rf_write_data_q;
  word_t                     rf_write_data_d;

  register_address_t         sel_destination;
  word_t                     sel_data;

  assign starve_at_limit = (starve_count_q == LIMIT);

  // Pick the winner; load has priority until the ALU has waited long enough.
  // Nothing is granted while reset is held.
  always_comb begin
    grant      = GRANT_NONE;
    alu_ready  = 1'b0;
    load_ready = 1'b0;
    if (reset_n) begin
      if (alu_valid && (!load_valid || starve_at_limit)) begin
        grant = GRANT_ALU;
      end else if (load_valid) begin
        grant = GRANT_LOAD;
      end
    end
    alu_ready  = (grant == GRANT_ALU);
    load_ready = (grant == GRANT_LOAD);
  end

  // Count consecutive cycles the ALU was left waiting behind a load.
  always_comb begin
    starve_count_d = starve_count_q;
    if (!alu_valid || grant == GRANT_ALU) begin
      starve_count_d = '0;
    end else if (grant == GRANT_LOAD && !starve_at_limit) begin
      starve_count_d = starve_count_q + 1'b1;
    end
  end

  // Select the winning payload and form the next register-file write.
  // A transfer to x0 is accepted but produces no write; address and data
  // then keep their previous values.
  always_comb begin
    sel_destination = load_destination;
    sel_data        = load_data;
    if (grant == GRANT_ALU) begin
      sel_destination = alu_destination;
      sel_data        = alu_data;
    end
    rf_write_enable_d = (grant != GRANT_NONE) && !is_zero_reg(sel_destination);
    rf_destination_d  = rf_destination_q;
    rf_write_data_d   = rf_write_data_q;
    if (rf_write_enable_d) begin
      rf_destination_d = sel_destination;
      rf_write_data_d  = sel_data;
    end
  end

  // Starvation counter and registered write port; reset discards any
  // write that has been captured but not yet presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_count_q    <= '0;
      rf_write_enable_q <= 1'b0;
      rf_destination_q  <= REG_ZERO;
      rf_write_data_q   <= '0;
    end else begin
      starve_count_q    <= starve_count_d;
      rf_write_enable_q <= rf_write_enable_d;
      rf_destination_q  <= rf_destination_d;
      rf_write_data_q   <= rf_write_data_d;
    end
  end

  assign rf_write_enable = rf_write_enable_q;
  assign rf_destination  = rf_destination_q;
  assign rf_write_data   = rf_write_data_q;

`ifdef WRITEBACK_SCOREBOARD_EN
  writeback_scoreboard u_scoreboard (
    .clk               (clk),
    .reset_n           (reset_n),
    .issue_valid       (issue_valid),
    .issue_destination (issue_destination),
    .clear_valid       (rf_write_enable_q),
    .clear_destination (rf_destination_q),
    .source1           (source1),
    .source2           (source2),
    .busy1             (busy1),
    .busy2             (busy2)
  );
`else
  // No reservation tracking: nothing is ever reported busy.
  logic scoreboard_inputs_unused;
  assign scoreboard_inputs_unused = ^{issue_valid, issue_destination, source1, source2};
  assign busy1 = 1'b0;
  assign busy2 = 1'b0;
`endif

endmodule
